// File: rtl/ctrl_pkg.sv
// Shared types and constants for the instruction-fetch control stage.
// Imported by ctrl_if and fetch_buf.
package ctrl_pkg;

    localparam logic [15:0] NOP_INSN = 16'hBF00;

    localparam int IF_ADDR_W = 16;

    typedef logic [IF_ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        START = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2,
        DROP  = 2'd3
    } if_state_t;

endpackage

// File: rtl/fetch_buf.sv
// Prefetch queue of {insn, pc} pairs between imem and the IR register.
// Flush wins over push; head is valid whenever count is non-zero.
module fetch_buf
    import ctrl_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int BUF_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [15:0]                push_insn,
    input  logic [ADDR_W-1:0]          push_pc,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(BUF_DEPTH):0] count,
    output logic [15:0]                head_insn,
    output logic [ADDR_W-1:0]          head_pc
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    logic [15:0]       insn_q [BUF_DEPTH];
    logic [ADDR_W-1:0] pc_q   [BUF_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != DEPTH_C) || do_pop);

    assign head_insn = insn_q[rd_ptr];
    assign head_pc   = pc_q[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            insn_q[wr_ptr] <= push_insn;
            pc_q[wr_ptr]   <= push_pc;
        end
    end

endmodule

// File: rtl/ctrl_if.sv
// Instruction-fetch control: single-outstanding imem requests, prefetch
// queue, registered IR/PC to decode, branch redirect with stale-ack drop.
module ctrl_if
    import ctrl_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                BUF_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_stall,
    input  logic              i_branch_taken,
    input  logic [ADDR_W-1:0] i_branch_target,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_ack,
    input  logic [15:0]       i_imem_rdata,
    output logic [15:0]       o_ir_r,
    output logic [ADDR_W-1:0] o_pc_r,
    output logic              o_ir_valid_r
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    if_state_t         state;
    if_state_t         state_nxt;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] drop_addr;
    logic [ADDR_W-1:0] tgt;
    logic              push;
    logic              pop;
    logic              flush;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_post;
    logic [15:0]       head_insn;
    logic [ADDR_W-1:0] head_pc;
    logic              unused_tgt0;

    assign unused_tgt0 = i_branch_target[0];
    assign tgt = {i_branch_target[ADDR_W-1:1], 1'b0};

    assign o_imem_req  = (state == FETCH) || (state == DROP);
    assign o_imem_addr = (state == DROP) ? drop_addr : fetch_pc;

    assign flush = i_branch_taken && (state != START);
    assign push  = (state == FETCH) && i_imem_ack && !i_branch_taken;
    assign pop   = !i_branch_taken && !i_stall && (count != '0);

    assign count_post = count + CNT_W'(push) - CNT_W'(pop);

    fetch_buf #(
        .ADDR_W    (ADDR_W),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_insn (i_imem_rdata),
        .push_pc   (fetch_pc),
        .pop       (pop),
        .flush     (flush),
        .count     (count),
        .head_insn (head_insn),
        .head_pc   (head_pc)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            START: state_nxt = FETCH;
            FETCH: begin
                if (i_branch_taken)
                    state_nxt = i_imem_ack ? FETCH : DROP;
                else if (i_imem_ack && count_post == DEPTH_C)
                    state_nxt = FULL;
            end
            FULL: begin
                if (i_branch_taken || count_post != DEPTH_C)
                    state_nxt = FETCH;
            end
            DROP: begin
                if (i_imem_ack)
                    state_nxt = FETCH;
            end
            default: state_nxt = START;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= START;
            fetch_pc  <= RESET_PC;
            drop_addr <= '0;
        end else begin
            state <= state_nxt;
            // Remember the address still owed an ack so req/addr stay stable.
            if (state == FETCH && i_branch_taken && !i_imem_ack)
                drop_addr <= fetch_pc;
            if (flush)
                fetch_pc <= tgt;
            else if (push)
                fetch_pc <= fetch_pc + ADDR_W'(2);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_ir_r       <= NOP_INSN;
            o_pc_r       <= '0;
            o_ir_valid_r <= 1'b0;
        end else if (i_branch_taken) begin
            o_ir_r       <= NOP_INSN;
            o_ir_valid_r <= 1'b0;
        end else if (!i_stall) begin
            if (pop) begin
                o_ir_r       <= head_insn;
                o_pc_r       <= head_pc;
                o_ir_valid_r <= 1'b1;
            end else begin
                o_ir_r       <= NOP_INSN;
                o_ir_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ctrl_if.sv
// Directed bench for ctrl_if: second instance covers the RESET_PC wrap case.
module tb_ctrl_if;
    import ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    addr_t       tgt = '0;
    logic        zw = 1'b1;
    logic        lat_ack = 1'b0;

    logic        req;
    addr_t       addr;
    logic        ack;
    logic [15:0] rdata;
    logic [15:0] ir;
    addr_t       pc;
    logic        vld;

    logic        req2;
    addr_t       addr2;
    logic [15:0] ir2;
    addr_t       pc2;
    logic        vld2;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign ack   = zw ? req : lat_ack;
    assign rdata = 16'h5A00 + addr;

    ctrl_if dut (
        .clk             (clk),
        .rst             (rst),
        .i_stall         (stall),
        .i_branch_taken  (br),
        .i_branch_target (tgt),
        .o_imem_req      (req),
        .o_imem_addr     (addr),
        .i_imem_ack      (ack),
        .i_imem_rdata    (rdata),
        .o_ir_r          (ir),
        .o_pc_r          (pc),
        .o_ir_valid_r    (vld)
    );

    ctrl_if #(.RESET_PC(16'hFFFC)) dut2 (
        .clk             (clk),
        .rst             (rst),
        .i_stall         (1'b0),
        .i_branch_taken  (1'b0),
        .i_branch_target (16'h0000),
        .o_imem_req      (req2),
        .o_imem_addr     (addr2),
        .i_imem_ack      (req2),
        .i_imem_rdata    (~addr2),
        .o_ir_r          (ir2),
        .o_pc_r          (pc2),
        .o_ir_valid_r    (vld2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        // reset state and zero-wait streaming
        tick();
        tick();
        chk("rst_req", 32'(req), 32'h0);
        chk("rst_ir", 32'(ir), 32'hBF00);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_vld", 32'(vld), 32'h0);
        chk("rst_req2", 32'(req2), 32'h0);
        rst = 1'b1;
        tick();
        chk("e1_req", 32'(req), 32'h1);
        chk("e1_addr", 32'(addr), 32'h0000);
        chk("w_addr0", 32'(addr2), 32'hFFFC);
        tick();
        chk("e2_addr", 32'(addr), 32'h0002);
        chk("e2_vld", 32'(vld), 32'h0);
        chk("w_addr1", 32'(addr2), 32'hFFFE);
        tick();
        chk("e3_addr", 32'(addr), 32'h0004);
        chk("e3_ir", 32'(ir), 32'h5A00);
        chk("e3_pc", 32'(pc), 32'h0000);
        chk("e3_vld", 32'(vld), 32'h1);
        chk("w_addr2", 32'(addr2), 32'h0000);
        chk("w_ir0", 32'(ir2), 32'h0003);
        chk("w_pc0", 32'(pc2), 32'hFFFC);
        tick();
        chk("e4_ir", 32'(ir), 32'h5A02);
        chk("e4_pc", 32'(pc), 32'h0002);
        chk("w_ir1", 32'(ir2), 32'h0001);
        chk("w_pc1", 32'(pc2), 32'hFFFE);

        // stall four cycles: queue fills, request stops, IR held
        stall = 1'b1;
        tick();
        chk("w_ir2", 32'(ir2), 32'hFFFF);
        chk("w_pc2", 32'(pc2), 32'h0000);
        chk("w_vld2", 32'(vld2), 32'h1);
        tick();
        tick();
        tick();
        chk("st_req", 32'(req), 32'h0);
        chk("st_ir", 32'(ir), 32'h5A02);
        chk("st_pc", 32'(pc), 32'h0002);
        chk("st_vld", 32'(vld), 32'h1);
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rel_ir", 32'(ir), 32'h5A04 + 32'(2 * i));
            chk("rel_pc", 32'(pc), 32'h0004 + 32'(2 * i));
            chk("rel_vld", 32'(vld), 32'h1);
        end

        // slow memory, branch while request to 0x0008 is pending
        do_reset();
        zw = 1'b1;
        for (int i = 0; i < 5; i++)
            tick();
        chk("sl_addr8", 32'(addr), 32'h0008);
        zw = 1'b0;
        tick();
        chk("sl_req", 32'(req), 32'h1);
        chk("sl_hold", 32'(addr), 32'h0008);
        br = 1'b1;
        tgt = 16'h0041;
        tick();
        br = 1'b0;
        chk("dr_req", 32'(req), 32'h1);
        chk("dr_addr", 32'(addr), 32'h0008);
        chk("dr_vld", 32'(vld), 32'h0);
        chk("dr_ir", 32'(ir), 32'hBF00);
        lat_ack = 1'b1;
        tick();
        lat_ack = 1'b0;
        chk("tg_req", 32'(req), 32'h1);
        chk("tg_addr", 32'(addr), 32'h0040);
        zw = 1'b1;
        tick();
        chk("tg_vld0", 32'(vld), 32'h0);
        tick();
        chk("tg_ir", 32'(ir), 32'h5A40);
        chk("tg_pc", 32'(pc), 32'h0040);
        chk("tg_vld", 32'(vld), 32'h1);

        // branch with ack of 0x0010 and stall in the same cycle
        do_reset();
        for (int i = 0; i < 9; i++)
            tick();
        chk("bs_addr", 32'(addr), 32'h0010);
        br = 1'b1;
        tgt = 16'h0100;
        stall = 1'b1;
        tick();
        br = 1'b0;
        stall = 1'b0;
        chk("bs_vld", 32'(vld), 32'h0);
        chk("bs_ir", 32'(ir), 32'hBF00);
        chk("bs_req", 32'(req), 32'h1);
        chk("bs_tgt", 32'(addr), 32'h0100);
        tick();
        chk("bs_vld1", 32'(vld), 32'h0);
        tick();
        chk("bs_ir2", 32'(ir), 32'h5B00);
        chk("bs_pc2", 32'(pc), 32'h0100);
        chk("bs_vld2", 32'(vld), 32'h1);

        // async reset with request outstanding, late ack ignored
        rst = 1'b0;
        tick();
        tick();
        zw = 1'b0;
        lat_ack = 1'b0;
        rst = 1'b1;
        tick();
        chk("ar_req", 32'(req), 32'h1);
        chk("ar_addr", 32'(addr), 32'h0000);
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("ar_drop", 32'(req), 32'h0);
        chk("ar_vld", 32'(vld), 32'h0);
        chk("ar_ir", 32'(ir), 32'hBF00);
        lat_ack = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        chk("ar_req1", 32'(req), 32'h1);
        chk("ar_addr1", 32'(addr), 32'h0000);
        chk("ar_vld1", 32'(vld), 32'h0);
        tick();
        chk("ar_vld2", 32'(vld), 32'h0);
        chk("ar_addr2", 32'(addr), 32'h0002);
        lat_ack = 1'b0;
        tick();
        chk("ar_ir3", 32'(ir), 32'h5A00);
        chk("ar_pc3", 32'(pc), 32'h0000);
        chk("ar_vld3", 32'(vld), 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
